// File: rtl/lpddr2_ca_decoder.sv
// LPDDR2 x16 device-side CA decoder: turns captured CA halves into one registered
// command per clock and tracks bank, mode-register, burst and power state.
module lpddr2_ca_decoder #(
  parameter int BA_BITS  = 3,
  parameter int ROW_BITS = 15,
  parameter int COL_BITS = 12,
  parameter int CA_BITS  = 10
) (
  input  logic                      ck,
  input  logic                      rst,
  input  logic                      cke,
  input  logic                      cs_n,
  input  logic [CA_BITS-1:0]        ca_r,
  input  logic [CA_BITS-1:0]        ca_f,
  output logic                      cmd_vld,
  output logic [3:0]                cmd,
  output logic [BA_BITS-1:0]        ba,
  output logic [ROW_BITS-1:0]       row,
  output logic [COL_BITS-1:0]       col,
  output logic                      ap,
  output logic                      ab,
  output logic [7:0]                ma,
  output logic [7:0]                op,
  output logic [(2**BA_BITS)-1:0]   bank_open,
  output logic [7:0]                mr1,
  output logic [7:0]                mr2,
  output logic [4:0]                bl,
  output logic                      rd_busy,
  output logic                      wr_busy,
  output logic [1:0]                pstate,
  output logic                      err,
  output logic [2:0]                err_code
);

  localparam int NBANK = 2**BA_BITS;

  localparam logic [3:0] CMD_MRW  = 4'd1;
  localparam logic [3:0] CMD_MRR  = 4'd2;
  localparam logic [3:0] CMD_REF  = 4'd3;
  localparam logic [3:0] CMD_PRE  = 4'd4;
  localparam logic [3:0] CMD_ACT  = 4'd5;
  localparam logic [3:0] CMD_WR   = 4'd6;
  localparam logic [3:0] CMD_RD   = 4'd7;
  localparam logic [3:0] CMD_BST  = 4'd8;
  localparam logic [3:0] CMD_PDE  = 4'd9;
  localparam logic [3:0] CMD_SRE  = 4'd10;
  localparam logic [3:0] CMD_DPDE = 4'd11;
  localparam logic [3:0] CMD_LPX  = 4'd12;

  localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
  localparam logic [2:0] ERR_CLOSED   = 3'd2;
  localparam logic [2:0] ERR_REF_OPEN = 3'd3;
  localparam logic [2:0] ERR_BST_IDLE = 3'd4;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd5;

  localparam logic [7:0] MR1_DEF = 8'h02;
  localparam logic [7:0] MR2_DEF = 8'h01;

  typedef enum logic [1:0] {
    PS_ACTIVE = 2'd0,
    PS_PD     = 2'd1,
    PS_SREF   = 2'd2,
    PS_DPD    = 2'd3
  } pstate_e;

  function automatic logic [4:0] burst_len(input logic [7:0] m);
    case (m[2:0])
      3'b011:  burst_len = 5'd8;
      3'b100:  burst_len = 5'd16;
      default: burst_len = 5'd4;
    endcase
  endfunction

  // Burst occupancy in clocks: BL/2 at double data rate.
  function automatic logic [3:0] burst_cycles(input logic [7:0] m);
    case (m[2:0])
      3'b011:  burst_cycles = 4'd4;
      3'b100:  burst_cycles = 4'd8;
      default: burst_cycles = 4'd2;
    endcase
  endfunction

  pstate_e              ps_q, ps_d;
  logic                 cmd_vld_q, cmd_vld_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic                 ap_q, ap_d;
  logic                 ab_q, ab_d;
  logic [7:0]           ma_q, ma_d;
  logic [7:0]           op_q, op_d;
  logic [NBANK-1:0]     bank_open_q, bank_open_d;
  logic [7:0]           mr1_q, mr1_d;
  logic [7:0]           mr2_q, mr2_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 dir_wr_q, dir_wr_d;
  logic                 rd_busy_q, rd_busy_d;
  logic                 wr_busy_q, wr_busy_d;
  logic                 err_q, err_d;
  logic [2:0]           err_code_q, err_code_d;

  logic [BA_BITS-1:0]   ca_ba;
  logic [ROW_BITS-1:0]  ca_row;
  logic [COL_BITS-1:0]  ca_col;
  logic [7:0]           ca_ma;
  logic [7:0]           ca_op;

  assign ca_ba  = BA_BITS'(ca_r[9:7]);
  assign ca_row = ROW_BITS'({ca_f[9:8], ca_r[6:2], ca_f[7:0]});
  assign ca_col = COL_BITS'({ca_f[9:1], ca_r[6:5], 1'b0});
  assign ca_ma  = {ca_f[1:0], ca_r[9:4]};
  assign ca_op  = ca_f[9:2];

  always_comb begin
    ps_d        = ps_q;
    cmd_vld_d   = 1'b0;
    cmd_d       = cmd_q;
    ba_d        = ba_q;
    row_d       = row_q;
    col_d       = col_q;
    ap_d        = ap_q;
    ab_d        = ab_q;
    ma_d        = ma_q;
    op_d        = op_q;
    bank_open_d = bank_open_q;
    mr1_d       = mr1_q;
    mr2_d       = mr2_q;
    cnt_d       = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    dir_wr_d    = dir_wr_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    case (ps_q)
      PS_ACTIVE: begin
        if (!cke) begin
          cmd_vld_d = 1'b1;
          if (cs_n) begin
            ps_d  = PS_PD;
            cmd_d = CMD_PDE;
          end else if (ca_r[2:0] == 3'b100) begin
            ps_d  = PS_SREF;
            cmd_d = CMD_SRE;
            if (bank_open_q != '0) begin
              err_d      = 1'b1;
              err_code_d = ERR_REF_OPEN;
            end
          end else if (ca_r[2:0] == 3'b011) begin
            ps_d  = PS_DPD;
            cmd_d = CMD_DPDE;
          end else begin
            ps_d       = PS_PD;
            cmd_d      = CMD_PDE;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end
        end else if (!cs_n) begin
          casez (ca_r[3:0])
            4'b??10: begin
              cmd_vld_d = 1'b1;
              cmd_d     = CMD_ACT;
              ba_d      = ca_ba;
              row_d     = ca_row;
              if (bank_open_q[ca_ba]) begin
                err_d      = 1'b1;
                err_code_d = ERR_ACT_OPEN;
              end else begin
                bank_open_d[ca_ba] = 1'b1;
              end
            end
            4'b?001, 4'b?101: begin
              cmd_vld_d = 1'b1;
              cmd_d     = ca_r[2] ? CMD_RD : CMD_WR;
              ba_d      = ca_ba;
              col_d     = ca_col;
              ap_d      = ca_f[0];
              if (!bank_open_q[ca_ba]) begin
                err_d      = 1'b1;
                err_code_d = ERR_CLOSED;
              end else begin
                // A new column command restarts the burst and may flip direction.
                cnt_d    = burst_cycles(mr1_q);
                dir_wr_d = !ca_r[2];
                if (ca_f[0]) begin
                  bank_open_d[ca_ba] = 1'b0;
                end
              end
            end
            4'b0011: begin
              cmd_vld_d = 1'b1;
              cmd_d     = CMD_BST;
              if (cnt_q != 4'd0) begin
                cnt_d = 4'd0;
              end else begin
                err_d      = 1'b1;
                err_code_d = ERR_BST_IDLE;
              end
            end
            4'b1011: begin
              cmd_vld_d = 1'b1;
              cmd_d     = CMD_PRE;
              ba_d      = ca_ba;
              ab_d      = ca_r[4];
              if (ca_r[4]) begin
                bank_open_d = '0;
              end else begin
                bank_open_d[ca_ba] = 1'b0;
              end
            end
            4'b?100: begin
              cmd_vld_d = 1'b1;
              cmd_d     = CMD_REF;
              ab_d      = ca_r[3];
              if (ca_r[3] && (bank_open_q != '0)) begin
                err_d      = 1'b1;
                err_code_d = ERR_REF_OPEN;
              end
            end
            4'b0000: begin
              cmd_vld_d = 1'b1;
              cmd_d     = CMD_MRW;
              ma_d      = ca_ma;
              op_d      = ca_op;
              if (ca_ma == 8'h01) begin
                mr1_d = ca_op;
              end else if (ca_ma == 8'h02) begin
                mr2_d = ca_op;
              end else if (ca_ma == 8'h3F) begin
                mr1_d       = MR1_DEF;
                mr2_d       = MR2_DEF;
                bank_open_d = '0;
                cnt_d       = 4'd0;
              end
            end
            4'b1000: begin
              cmd_vld_d = 1'b1;
              cmd_d     = CMD_MRR;
              ma_d      = ca_ma;
            end
            default: begin
              cmd_vld_d = 1'b0;
            end
          endcase
        end
      end
      default: begin
        // Low-power states ignore CA until CKE returns high.
        if (cke) begin
          ps_d      = PS_ACTIVE;
          cmd_vld_d = 1'b1;
          cmd_d     = CMD_LPX;
          if (ps_q == PS_DPD) begin
            bank_open_d = '0;
            mr1_d       = MR1_DEF;
            mr2_d       = MR2_DEF;
          end
        end
      end
    endcase

    rd_busy_d = (cnt_d != 4'd0) && !dir_wr_d;
    wr_busy_d = (cnt_d != 4'd0) && dir_wr_d;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      ps_q        <= PS_ACTIVE;
      cmd_vld_q   <= 1'b0;
      cmd_q       <= 4'd0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ap_q        <= 1'b0;
      ab_q        <= 1'b0;
      ma_q        <= 8'd0;
      op_q        <= 8'd0;
      bank_open_q <= '0;
      mr1_q       <= MR1_DEF;
      mr2_q       <= MR2_DEF;
      cnt_q       <= 4'd0;
      dir_wr_q    <= 1'b0;
      rd_busy_q   <= 1'b0;
      wr_busy_q   <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      ps_q        <= ps_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ap_q        <= ap_d;
      ab_q        <= ab_d;
      ma_q        <= ma_d;
      op_q        <= op_d;
      bank_open_q <= bank_open_d;
      mr1_q       <= mr1_d;
      mr2_q       <= mr2_d;
      cnt_q       <= cnt_d;
      dir_wr_q    <= dir_wr_d;
      rd_busy_q   <= rd_busy_d;
      wr_busy_q   <= wr_busy_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_vld   = cmd_vld_q;
  assign cmd       = cmd_q;
  assign ba        = ba_q;
  assign row       = row_q;
  assign col       = col_q;
  assign ap        = ap_q;
  assign ab        = ab_q;
  assign ma        = ma_q;
  assign op        = op_q;
  assign bank_open = bank_open_q;
  assign mr1       = mr1_q;
  assign mr2       = mr2_q;
  assign bl        = burst_len(mr1_q);
  assign rd_busy   = rd_busy_q;
  assign wr_busy   = wr_busy_q;
  assign pstate    = ps_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_lpddr2_ca_decoder.sv
// Directed bench for lpddr2_ca_decoder: encodes CA commands, applies one per clock
// and compares registered outputs against hand-computed values.
module tb_lpddr2_ca_decoder;

  logic        ck;
  logic        rst;
  logic        cke;
  logic        cs_n;
  logic [9:0]  ca_r;
  logic [9:0]  ca_f;
  logic        cmd_vld;
  logic [3:0]  cmd;
  logic [2:0]  ba;
  logic [14:0] row;
  logic [11:0] col;
  logic        ap;
  logic        ab;
  logic [7:0]  ma;
  logic [7:0]  op;
  logic [7:0]  bank_open;
  logic [7:0]  mr1;
  logic [7:0]  mr2;
  logic [4:0]  bl;
  logic        rd_busy;
  logic        wr_busy;
  logic [1:0]  pstate;
  logic        err;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;

  lpddr2_ca_decoder dut (
    .ck(ck), .rst(rst), .cke(cke), .cs_n(cs_n), .ca_r(ca_r), .ca_f(ca_f),
    .cmd_vld(cmd_vld), .cmd(cmd), .ba(ba), .row(row), .col(col), .ap(ap), .ab(ab),
    .ma(ma), .op(op), .bank_open(bank_open), .mr1(mr1), .mr2(mr2), .bl(bl),
    .rd_busy(rd_busy), .wr_busy(wr_busy), .pstate(pstate), .err(err),
    .err_code(err_code)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one clock of inputs; outputs are sampled 1 ns after the capturing edge.
  task automatic cyc(input logic k, input logic c, input logic [9:0] r, input logic [9:0] f);
    cke  = k;
    cs_n = c;
    ca_r = r;
    ca_f = f;
    @(posedge ck);
    #1;
  endtask

  task automatic send(input logic [19:0] v);
    cyc(1'b1, 1'b0, v[19:10], v[9:0]);
  endtask

  task automatic desel();
    cyc(1'b1, 1'b1, 10'd0, 10'd0);
  endtask

  function automatic logic [19:0] e_act(input logic [2:0] b, input logic [14:0] rw);
    e_act = {b, rw[12:8], 2'b10, rw[14:13], rw[7:0]};
  endfunction

  function automatic logic [19:0] e_col(input logic rd, input logic [2:0] b,
                                        input logic [11:0] c, input logic a);
    e_col = {b, c[2:1], 2'b00, rd, 2'b01, c[11:3], a};
  endfunction

  function automatic logic [19:0] e_pre(input logic [2:0] b, input logic a);
    e_pre = {b, 2'b00, a, 4'b1011, 10'd0};
  endfunction

  function automatic logic [19:0] e_ref(input logic a);
    e_ref = {6'd0, a, 3'b100, 10'd0};
  endfunction

  function automatic logic [19:0] e_mrw(input logic [7:0] m, input logic [7:0] o);
    e_mrw = {m[5:0], 4'b0000, o, m[7:6]};
  endfunction

  localparam logic [19:0] E_BST = {10'b0000000011, 10'd0};
  localparam logic [19:0] E_NOP = {10'b0000000111, 10'd0};

  logic [19:0] v;

  initial begin
    rst = 1'b1; cke = 1'b1; cs_n = 1'b1; ca_r = '0; ca_f = '0;
    desel();
    // Reset beats a concurrent ACT.
    send(e_act(3'd1, 15'h0123));
    rst = 1'b0;
    chk("rst_cmd_vld", cmd_vld, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_bank_open", bank_open, 0);
    chk("rst_mr1", mr1, 8'h02);
    chk("rst_mr2", mr2, 8'h01);
    chk("rst_bl", bl, 4);
    chk("rst_pstate", pstate, 0);
    chk("rst_busy", {rd_busy, wr_busy}, 0);
    chk("rst_err", {err, err_code}, 0);

    send(e_act(3'd2, 15'h1ABC));
    chk("act_cmd", {cmd_vld, cmd}, {1'b1, 4'd5});
    chk("act_ba", ba, 2);
    chk("act_row", row, 15'h1ABC);
    chk("act_bank_open", bank_open, 8'h04);
    chk("act_err", err, 0);

    send(e_col(1'b1, 3'd2, 12'h3F8, 1'b0));
    chk("rd_cmd", {cmd_vld, cmd}, {1'b1, 4'd7});
    chk("rd_col", col, 12'h3F8);
    chk("rd_ap", ap, 0);
    chk("rd_busy_c1", {rd_busy, wr_busy}, 2'b10);
    desel();
    chk("rd_busy_c2", rd_busy, 1);
    chk("desel_no_vld", cmd_vld, 0);
    chk("col_hold", col, 12'h3F8);
    desel();
    chk("rd_busy_done", rd_busy, 0);

    send(e_mrw(8'd1, 8'h03));
    chk("mrw_cmd", {cmd_vld, cmd}, {1'b1, 4'd1});
    chk("mrw_ma_op", {ma, op}, {8'd1, 8'h03});
    chk("mrw_mr1", mr1, 8'h03);
    chk("mrw_bl8", bl, 8);
    send(e_col(1'b0, 3'd2, 12'h010, 1'b0));
    chk("wr_cmd", {cmd_vld, cmd}, {1'b1, 4'd6});
    chk("wr_busy_c1", {rd_busy, wr_busy}, 2'b01);
    send(E_BST);
    chk("bst_cmd", {cmd_vld, cmd}, {1'b1, 4'd8});
    chk("bst_drops_busy", wr_busy, 0);
    chk("bst_no_err", err, 0);
    send(e_col(1'b0, 3'd2, 12'h020, 1'b0));
    for (int i = 0; i < 3; i++) begin
      desel();
      chk("wr_busy_hold", wr_busy, 1);
    end
    desel();
    chk("wr_busy_done", wr_busy, 0);
    send(E_BST);
    chk("bst_idle_err", {err, err_code}, {1'b1, 3'd4});
    chk("bst_idle_vld", {cmd_vld, cmd}, {1'b1, 4'd8});

    send(e_act(3'd5, 15'h0001));
    chk("act5_open", bank_open, 8'h24);
    send(e_act(3'd5, 15'h7FFF));
    chk("act_open_err", {err, err_code}, {1'b1, 3'd1});
    chk("act_open_vld", {cmd_vld, cmd}, {1'b1, 4'd5});
    chk("act_open_row", row, 15'h7FFF);
    chk("act_open_bank", bank_open, 8'h24);
    send(e_col(1'b1, 3'd6, 12'h000, 1'b0));
    chk("rd_closed_err", {err, err_code}, {1'b1, 3'd2});
    chk("rd_closed_busy", {rd_busy, wr_busy}, 0);
    send(e_pre(3'd0, 1'b1));
    chk("preab_cmd", {cmd_vld, cmd, ab}, {1'b1, 4'd4, 1'b1});
    chk("preab_bank", bank_open, 0);
    chk("preab_err", err, 0);

    cyc(1'b0, 1'b1, E_NOP[19:10], 10'd0);
    chk("pde_cmd", {cmd_vld, cmd}, {1'b1, 4'd9});
    chk("pde_pstate", pstate, 1);
    cyc(1'b0, 1'b0, E_NOP[19:10], 10'd0);
    chk("pd_nop", {cmd_vld, pstate}, {1'b0, 2'd1});
    v = e_act(3'd1, 15'h0005);
    cyc(1'b0, 1'b0, v[19:10], v[9:0]);
    chk("pd_act_ignored", {cmd_vld, bank_open}, {1'b0, 8'h00});
    cyc(1'b1, 1'b1, 10'd0, 10'd0);
    chk("pdx_cmd", {cmd_vld, cmd}, {1'b1, 4'd12});
    chk("pdx_pstate", pstate, 0);

    send(e_act(3'd0, 15'h0005));
    send(e_act(3'd3, 15'h0006));
    chk("banks03", bank_open, 8'h09);
    send(e_mrw(8'd2, 8'h55));
    chk("mrw_mr2", mr2, 8'h55);
    send(e_mrw(8'h3F, 8'h00));
    chk("mrst_ma", {cmd_vld, cmd, ma}, {1'b1, 4'd1, 8'h3F});
    chk("mrst_bank", bank_open, 0);
    chk("mrst_mr", {mr1, mr2}, {8'h02, 8'h01});
    chk("mrst_bl", bl, 4);
    send(e_ref(1'b1));
    chk("refab_cmd", {cmd_vld, cmd, ab}, {1'b1, 4'd3, 1'b1});
    chk("refab_err", err, 0);

    send(e_act(3'd1, 15'h0000));
    v = e_ref(1'b0);
    cyc(1'b0, 1'b0, v[19:10], v[9:0]);
    chk("sre_cmd", {cmd_vld, cmd}, {1'b1, 4'd10});
    chk("sre_pstate", pstate, 2);
    chk("sre_err", {err, err_code}, {1'b1, 3'd3});
    cyc(1'b1, 1'b1, 10'd0, 10'd0);
    chk("srx", {cmd_vld, cmd, pstate}, {1'b1, 4'd12, 2'd0});
    chk("srx_bank", bank_open, 8'h02);

    send(e_mrw(8'd1, 8'h04));
    chk("bl16", bl, 16);
    cyc(1'b0, 1'b0, E_BST[19:10], 10'd0);
    chk("dpde", {cmd_vld, cmd, pstate}, {1'b1, 4'd11, 2'd3});
    cyc(1'b1, 1'b1, 10'd0, 10'd0);
    chk("dpdx", {cmd_vld, cmd, pstate}, {1'b1, 4'd12, 2'd0});
    chk("dpdx_state", {bank_open, mr1}, {8'h00, 8'h02});

    v = e_mrw(8'd1, 8'h00);
    cyc(1'b0, 1'b0, v[19:10], v[9:0]);
    chk("illegal_err", {err, err_code, pstate}, {1'b1, 3'd5, 2'd1});
    cyc(1'b1, 1'b1, 10'd0, 10'd0);
    chk("illegal_exit", pstate, 0);

    send(e_mrw(8'd1, 8'h04));
    send(e_act(3'd4, 15'h0000));
    send(e_act(3'd7, 15'h0000));
    chk("banks47", bank_open, 8'h90);
    send(e_col(1'b0, 3'd7, 12'h800, 1'b1));
    chk("wrap_fields", {ap, col}, {1'b1, 12'h800});
    chk("wrap_bank", bank_open, 8'h10);
    chk("wrap_busy", {rd_busy, wr_busy}, 2'b01);
    send(e_col(1'b1, 3'd4, 12'h004, 1'b0));
    chk("seamless_dir", {rd_busy, wr_busy}, 2'b10);
    desel();
    chk("bl16_busy", rd_busy, 1);
    rst = 1'b1;
    send(e_col(1'b1, 3'd4, 12'h008, 1'b0));
    rst = 1'b0;
    chk("midrst_busy", {rd_busy, wr_busy}, 0);
    chk("midrst_bank", bank_open, 0);
    chk("midrst_vld", cmd_vld, 0);
    chk("midrst_mr1", mr1, 8'h02);
    desel();
    chk("post_rst_busy", rd_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
